// File: rtl/sb_frame_deserializer_pkg.sv
// Shared types and default parameter values for the sideband frame deserializer.
// Imported by the interface, the receive FIFO and the top module.
package sb_deser_pkg;

    // Encodings are fixed so the state can be probed or forced by number.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        STOP = 2'b10
    } deser_state_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_STOP_BITS  = 1;
    localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/sb_frame_deserializer_if.sv
// Received-word stream between the deserializer and its consumer.
// The master side produces out_data/out_valid and the slave side returns out_ready.
interface sb_frame_deserializer_if
    import sb_deser_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/sb_rx_fifo.sv
// Receive-word FIFO: DEPTH entries (power of two), pointers with a wrap bit.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sb_rx_fifo
    import sb_deser_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sb_frame_deserializer.sv
// Serial sideband frame receiver: start bit, DATA_W data bits, STOP_BITS stop bits,
// good words are queued in sb_rx_fifo and presented on a valid/ready stream.
module sb_frame_deserializer
    import sb_deser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LSB_FIRST  = 1,
    parameter int STOP_BITS  = DEF_STOP_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_bit,
    sb_frame_deserializer_if.master stream,
    output logic                    frame_err,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    deser_state_e      state_q;
    deser_state_e      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic              push;
    logic              err_set;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] sh,
                                                     input logic              b);
        if (LSB_FIRST != 0) begin
            return {b, sh[DATA_W-1:1]};
        end else begin
            return {sh[DATA_W-2:0], b};
        end
    endfunction

    // Next-state logic; the counter is reused for stop bits once the data field is full.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        push    = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !in_bit) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    sh_d = insert_bit(sh_q, in_bit);
                    if (cnt_q == DATA_LAST) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (!in_bit) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == STOP_LAST) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            frame_err <= err_set;
            // A simultaneous pop frees the slot, so only an unserved full FIFO drops.
            overflow  <= push && fifo_full && !pop;
        end
    end

    assign busy = (state_q != IDLE);

    assign stream.out_valid = !fifo_empty;
    assign pop              = stream.out_valid && stream.out_ready;

    sb_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sh_q),
        .pop       (pop),
        .pop_data  (stream.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sb_frame_deserializer.sv
// Scoreboard bench: two receivers (LSB-first/1 stop, MSB-first/2 stop) share clk and rst;
// expected words are queued as frames are driven and compared when the stream hands them off.
module tb_sb_frame_deserializer;

    logic clk = 1'b0;
    logic rst;
    logic en_a, bit_a, ferr_a, ovf_a, busy_a;
    logic en_b, bit_b, ferr_b, ovf_b, busy_b;

    int n_chk = 0;
    int n_err = 0;
    int ferr_cnt_a = 0;
    int ovf_cnt_a  = 0;
    int ferr_cnt_b = 0;
    int ovf_cnt_b  = 0;
    int ferr_snap;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    always #5 clk = ~clk;

    sb_frame_deserializer_if #(.DATA_W(8)) if_a ();
    sb_frame_deserializer_if #(.DATA_W(8)) if_b ();

    sb_frame_deserializer #(
        .DATA_W(8), .LSB_FIRST(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .in_bit(bit_a), .stream(if_a),
        .frame_err(ferr_a), .overflow(ovf_a), .busy(busy_a)
    );

    sb_frame_deserializer #(
        .DATA_W(8), .LSB_FIRST(0), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .in_bit(bit_b), .stream(if_b),
        .frame_err(ferr_b), .overflow(ovf_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Handshakes are sampled on the falling edge, ahead of the rising edge that pops.
    always @(negedge clk) begin : mon_a
        logic [31:0] e;
        if (rst) begin
            if (if_a.out_valid && if_a.out_ready) begin
                if (exp_a.size() != 0) e = 32'(exp_a.pop_front());
                else                   e = 32'hDEAD;
                check_eq("a_data", 32'(if_a.out_data), e);
            end
            check_eq("a_excl", 32'(ferr_a & ovf_a), 32'd0);
            if (ferr_a) ferr_cnt_a++;
            if (ovf_a)  ovf_cnt_a++;
        end
    end

    always @(negedge clk) begin : mon_b
        logic [31:0] e;
        if (rst) begin
            if (if_b.out_valid && if_b.out_ready) begin
                if (exp_b.size() != 0) e = 32'(exp_b.pop_front());
                else                   e = 32'hDEAD;
                check_eq("b_data", 32'(if_b.out_data), e);
            end
            if (ferr_b) ferr_cnt_b++;
            if (ovf_b)  ovf_cnt_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int idx, input logic b);
        if (idx == 0) bit_a = b;
        else          bit_b = b;
        tick();
    endtask

    // Start bit, eight data bits, then nstop stop bits taken from stops[0] upward.
    task automatic send(input int idx, input logic [7:0] d, input bit lsb,
                        input logic [1:0] stops, input int nstop, input bit rdy_stop);
        drv(idx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drv(idx, lsb ? d[i] : d[7-i]);
        end
        for (int s = 0; s < nstop; s++) begin
            if (rdy_stop && idx == 0) if_a.out_ready = 1'b1;
            drv(idx, stops[s]);
        end
        if (idx == 0) bit_a = 1'b1;
        else          bit_b = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] basic;
        basic = 8'hA5;
        rst = 1'b0;
        en_a = 1'b1; bit_a = 1'b1;
        en_b = 1'b1; bit_b = 1'b1;
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;
        repeat (3) tick();

        check_eq("a_rst_valid", 32'(if_a.out_valid), 32'd0);
        check_eq("a_rst_data",  32'(if_a.out_data),  32'd0);
        check_eq("a_rst_busy",  32'(busy_a),         32'd0);
        check_eq("a_rst_ferr",  32'(ferr_a),         32'd0);
        check_eq("a_rst_ovf",   32'(ovf_a),          32'd0);
        check_eq("b_rst_valid", 32'(if_b.out_valid), 32'd0);
        check_eq("b_rst_busy",  32'(busy_b),         32'd0);
        rst = 1'b1;

        // Basic frame: start on the first edge after reset release, word valid one edge after stop.
        drv(0, 1'b0);
        check_eq("a_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 8; i++) drv(0, basic[i]);
        bit_a = 1'b1;
        check_eq("a_lat_early", 32'(if_a.out_valid), 32'd0);
        tick();
        check_eq("a_lat_valid", 32'(if_a.out_valid), 32'd1);
        check_eq("a_lat_data",  32'(if_a.out_data),  32'hA5);
        check_eq("a_idle_busy", 32'(busy_a),         32'd0);
        repeat (2) tick();
        check_eq("a_hold", 32'(if_a.out_data), 32'hA5);
        exp_a.push_back(8'hA5);
        if_a.out_ready = 1'b1;
        repeat (2) tick();
        check_eq("a_empty_after", 32'(if_a.out_valid), 32'd0);

        // MSB-first receiver with two good stop bits, same line pattern.
        if_b.out_ready = 1'b1;
        exp_b.push_back(8'hA5);
        send(1, 8'hA5, 1'b0, 2'b11, 2, 1'b0);
        repeat (3) tick();
        check_eq("b_msb_drained", 32'(exp_b.size()), 32'd0);

        // Bad stop bit: one frame_err pulse in the cycle after, nothing queued.
        send(0, 8'h3C, 1'b1, 2'b00, 1, 1'b0);
        check_eq("a_ferr_pulse", 32'(ferr_a), 32'd1);
        check_eq("a_ferr_busy",  32'(busy_a), 32'd0);
        tick();
        check_eq("a_ferr_once",    32'(ferr_a),          32'd0);
        check_eq("a_ferr_novalid", 32'(if_a.out_valid),  32'd0);
        check_eq("a_ferr_cnt",     32'(ferr_cnt_a),      32'd1);

        // Overflow: five back-to-back frames into a stalled four-entry FIFO.
        if_a.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_a.push_back(8'(k));
            send(0, 8'(k), 1'b1, 2'b01, 1, 1'b0);
        end
        check_eq("a_ovf_pulse", 32'(ovf_a),          32'd1);
        check_eq("a_ovf_head",  32'(if_a.out_data),  32'h01);
        tick();
        check_eq("a_ovf_cnt",   32'(ovf_cnt_a),      32'd1);
        check_eq("a_ovf_noerr", 32'(ferr_cnt_a),     32'd1);

        // Full FIFO with push and pop on the same edge: both succeed, no overflow.
        exp_a.push_back(8'h06);
        send(0, 8'h06, 1'b1, 2'b01, 1, 1'b1);
        repeat (8) tick();
        check_eq("a_full_pp_ovf", 32'(ovf_cnt_a),    32'd1);
        check_eq("a_drain",       32'(exp_a.size()), 32'd0);

        // Two-stop-bit error followed immediately by a good frame.
        exp_b.push_back(8'h81);
        send(1, 8'h7E, 1'b0, 2'b01, 2, 1'b0);
        send(1, 8'h81, 1'b0, 2'b11, 2, 1'b0);
        repeat (4) tick();
        check_eq("b_ferr_cnt", 32'(ferr_cnt_b),    32'd1);
        check_eq("b_ovf_cnt",  32'(ovf_cnt_b),     32'd0);
        check_eq("b_next",     32'(exp_b.size()),  32'd0);

        // Reset mid-frame discards the partial word and the queued word.
        if_a.out_ready = 1'b0;
        send(0, 8'h11, 1'b1, 2'b01, 1, 1'b0);
        tick();
        check_eq("a_pre_rst_valid", 32'(if_a.out_valid), 32'd1);
        drv(0, 1'b0);
        for (int i = 0; i < 3; i++) drv(0, 1'b1);
        rst = 1'b0;
        bit_a = 1'b1;
        #1;
        check_eq("a_mid_rst_busy",  32'(busy_a),         32'd0);
        check_eq("a_mid_rst_valid", 32'(if_a.out_valid), 32'd0);
        check_eq("a_mid_rst_data",  32'(if_a.out_data),  32'd0);
        tick();
        tick();
        rst = 1'b1;
        ferr_snap = ferr_cnt_a;
        if_a.out_ready = 1'b1;
        exp_a.push_back(8'h5A);
        send(0, 8'h5A, 1'b1, 2'b01, 1, 1'b0);
        repeat (4) tick();
        check_eq("a_post_rst_q",    32'(exp_a.size()), 32'd0);
        check_eq("a_post_rst_ferr", 32'(ferr_cnt_a),   32'(ferr_snap));
        check_eq("a_post_rst_valid", 32'(if_a.out_valid), 32'd0);

        check_eq("a_final_q", 32'(exp_a.size()), 32'd0);
        check_eq("b_final_q", 32'(exp_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sb_frame_deserializer.md
SB_FRAME_DESERIALIZER -- requirements
Module: sb_frame_deserializer

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame, legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first data bit received is bit 0; 0 = first data bit received is bit DATA_W-1.
REQ-003 Parameter STOP_BITS, default 1: number of stop bits per frame, legal range 1..2.
REQ-004 Parameter FIFO_DEPTH, default 4: number of receive words buffered, power of two, minimum 2.
REQ-005 clk  input  1  clock; all sampling is on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  receiver enable.
REQ-008 in_bit  input  1  serial sideband line, one bit per clk, idle-high.
REQ-009 out_data  output  DATA_W  head-of-FIFO word.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
REQ-014 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, DATA and STOP.
REQ-016 IDLE: with en=1 and in_bit=0 (start bit), go to DATA and clear the bit counter; any other input stays in IDLE.
REQ-017 DATA: sample in_bit every cycle, place it at the position set by LSB_FIRST, and go to STOP after DATA_W samples.
REQ-018 STOP: sample STOP_BITS cycles.
  - All stop samples = 1: push the assembled word, then go to IDLE.
  - Any stop sample = 0: pulse frame_err for one cycle in the cycle after that sample, discard the word, and go to IDLE immediately.
REQ-019 Back-to-back frames SHALL be received with no idle gap: a 0 in the cycle after the last stop bit is a new start bit.
REQ-020 en=0 in DATA or STOP SHALL abort to IDLE on the next edge, with no push, no frame_err and no overflow.
REQ-021 Bit counter width SHALL be $clog2(DATA_W+1); the counter SHALL NOT wrap within a frame.
REQ-022 Latency: out_valid SHALL rise on the edge after the final stop bit is sampled when the FIFO was empty; there is no combinational bypass.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Push while the FIFO is full and there is no pop SHALL drop the word, pulse overflow for one cycle and leave the FIFO contents unchanged.
REQ-025 Push and pop in the same cycle:
  - FIFO full: both succeed, with no overflow.
  - FIFO empty: the push succeeds, and out_valid is 1 on the next cycle.
REQ-026 frame_err and overflow SHALL never assert in the same cycle.

Reset
REQ-027 While rst=0:
  - the FSM SHALL be in IDLE;
  - the bit counter, shift register and FIFO pointers SHALL be 0;
  - out_data, out_valid, frame_err, overflow and busy SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial word and empty the FIFO.
REQ-029 After rst deasserts, the first start bit SHALL be detectable on the first rising edge.

Structure
REQ-030 Package sb_deser_pkg SHALL hold:
  - the state typedef with fixed encodings IDLE=2'b00, DATA=2'b01, STOP=2'b10;
  - the default values of DATA_W, STOP_BITS and FIFO_DEPTH.
REQ-031 The FIFO SHALL be one sub-module, sb_rx_fifo (parameters WIDTH and DEPTH; push, pop, full and empty ports), instantiated once.
REQ-032 The FSM, shift register and counter SHALL reside in the top module.

Verification
REQ-033 Basic frame:
  - Stimulus: DATA_W=8, LSB_FIRST=1, STOP_BITS=1; start at cycle 0; bits 1,0,1,0,0,1,0,1; stop 1.
  - Response: out_data=0xA5 with out_valid=1 at cycle 10.
REQ-034 MSB-first:
  - Stimulus: LSB_FIRST=0, same bit stream as REQ-033.
  - Response: out_data=0xA5.
REQ-035 Bad stop bit:
  - Stimulus: frame 0x3C with stop bit 0.
  - Response: one frame_err pulse, no out_valid, busy=0 on the next cycle.
REQ-036 Overflow and ordering:
  - Stimulus: out_ready=0; five back-to-back good frames 0x01..0x05 with FIFO_DEPTH=4.
  - Response: one overflow pulse on the fifth frame; draining returns 0x01, 0x02, 0x03, 0x04 in order.
REQ-037 Two-stop-bit error:
  - Stimulus: STOP_BITS=2, frame 0x7E with stop bits 1,0.
  - Response: frame_err pulses once; a start bit in the next cycle yields the following frame correctly.
REQ-038 Reset mid-frame:
  - Stimulus: rst=0 at the 4th data bit, released two cycles later, then a clean frame 0x5A.
  - Response: only 0x5A is delivered; no frame_err.
